program_loader: RTL and testbench

//  Upstream boot stage of pipelined_risc_v_cpu. Receives a program as a byte stream

---
 rtl/program_loader_if.sv | 27 ++
 rtl/program_loader.sv | 133 +++++++++++++
 tb/tb_program_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the boot loader.
// Handshake: a byte transfers on the rising clk edge where byte_valid && byte_ready
// are both 1. byte_ready is registered in the loader and never depends on byte_valid.
// The source holds byte_in stable while byte_valid is 1 and the byte has not been taken.
interface program_loader_if #(
   parameter int ADD_WIDTH = 4,
   parameter int WIDTH     = 32
);
   logic [7:0]           byte_in;
   logic                 byte_valid;
   logic                 byte_ready;
   logic                 mem_wen;
   logic [ADD_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]     mem_wdata;

   // Byte source / memory observer side
   modport master (
      output byte_in, byte_valid,
      input  byte_ready, mem_wen, mem_addr, mem_wdata
   );

   // Loader side
   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, mem_wen, mem_addr, mem_wdata
   );
endinterface

// File: rtl/program_loader.sv
// Boot-stage program loader: packs a little-endian byte stream into 32-bit words,
// writes them to program memory at 0..DEPTH-1, then checks a trailing XOR checksum
// byte. The CPU is held in reset (cpu_rst=0) until a load ends with a good checksum.
module program_loader #(
   parameter int DEPTH     = 16,
   parameter int ADD_WIDTH = 4,
   parameter int WIDTH     = 32
) (
   input  logic               clk,
   input  logic               rst,          // asynchronous, active low
   input  logic               load_start,   // 1-cycle pulse, wins over everything
   program_loader_if.slave    bus,
   output logic               cpu_rst,      // active-low CPU reset, 1 only in DONE
   output logic               load_done,
   output logic               load_error,
   output logic [2:0]         o_state       // FSM state for debug/checkers
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_t;

   localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);

   state_t               r_state,    w_next_state;
   logic [1:0]           r_byte_cnt, w_next_cnt;
   logic [7:0]           r_checksum, w_next_sum;
   logic [ADD_WIDTH-1:0] r_addr,     w_next_addr;
   logic [WIDTH-1:0]     r_wdata,    w_next_data;
   logic                 r_ready,    w_next_ready;
   logic                 r_wen,      w_next_wen;
   logic                 r_cpu_rst,  w_next_cpu_rst;
   logic                 r_done,     w_next_done;
   logic                 r_error,    w_next_error;
   logic                 w_accept;

   // r_ready is 1 exactly in LOAD/CHECK, so an accept can only happen in those states
   assign w_accept = bus.byte_valid && r_ready;

   // Next-state, datapath and registered-output decode
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_byte_cnt;
      w_next_sum   = r_checksum;
      w_next_addr  = r_addr;
      w_next_data  = r_wdata;
      if (load_start) begin
         // restart from any state; a byte offered this cycle is dropped
         w_next_state = LOAD;
         w_next_cnt   = 2'd0;
         w_next_sum   = 8'd0;
         w_next_addr  = '0;
         w_next_data  = '0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_accept) begin
                  w_next_data[{r_byte_cnt, 3'b000} +: 8] = bus.byte_in;
                  w_next_sum = r_checksum ^ bus.byte_in;
                  w_next_cnt = r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     w_next_state = WRITE;
                  end
               end
            end
            WRITE: begin
               // last word written: address stays, never wraps back to 0
               if (r_addr == LAST_ADDR) begin
                  w_next_state = CHECK;
               end else begin
                  w_next_addr  = r_addr + 1'b1;
                  w_next_state = LOAD;
               end
            end
            CHECK: begin
               if (w_accept) begin
                  w_next_state = (bus.byte_in == r_checksum) ? DONE : ERROR;
               end
            end
            default: begin
               // IDLE, DONE, ERROR hold until load_start
            end
         endcase
      end
      w_next_ready   = (w_next_state == LOAD) || (w_next_state == CHECK);
      w_next_wen     = (w_next_state == WRITE);
      w_next_cpu_rst = (w_next_state == DONE);
      w_next_done    = (w_next_state == DONE);
      w_next_error   = (w_next_state == ERROR);
   end

   // State and registered outputs, cleared asynchronously by rst
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_byte_cnt <= 2'd0;
         r_checksum <= 8'd0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_ready    <= 1'b0;
         r_wen      <= 1'b0;
         r_cpu_rst  <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_byte_cnt <= w_next_cnt;
         r_checksum <= w_next_sum;
         r_addr     <= w_next_addr;
         r_wdata    <= w_next_data;
         r_ready    <= w_next_ready;
         r_wen      <= w_next_wen;
         r_cpu_rst  <= w_next_cpu_rst;
         r_done     <= w_next_done;
         r_error    <= w_next_error;
      end
   end

   assign bus.byte_ready = r_ready;
   assign bus.mem_wen    = r_wen;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wdata  = r_wdata;
   assign cpu_rst        = r_cpu_rst;
   assign load_done      = r_done;
   assign load_error     = r_error;
   assign o_state        = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: byte driver, memory-write scoreboard, scenario sequence.
module tb_program_loader;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_DONE = 3'd4;
   localparam logic [2:0] ST_ERR  = 3'd5;

   logic       clk;
   logic       rst;
   logic       load_start;
   logic       cpu_rst;
   logic       load_done;
   logic       load_error;
   logic [2:0] o_state;

   program_loader_if #(.ADD_WIDTH(4), .WIDTH(32)) bus ();

   program_loader #(.DEPTH(16), .ADD_WIDTH(4), .WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .bus        (bus),
      .cpu_rst    (cpu_rst),
      .load_done  (load_done),
      .load_error (load_error),
      .o_state    (o_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [35:0] exp_q[$];          // {addr, word}
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          tog     = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Every write must match the oldest expected word; byte_ready must be low meanwhile
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.mem_wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_wen_addr", 64'(bus.mem_addr), 64'hFFFF);
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            check_val("mem_write", {28'd0, bus.mem_addr, bus.mem_wdata}, {28'd0, e});
         end
         check_val("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit throttle);
      bit acc;
      int budget;
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 50) begin
         @(negedge clk);
         budget++;
         tog = throttle ? !tog : 1'b1;
         bus.byte_in    = b;
         bus.byte_valid = tog;
         acc = bus.byte_valid && bus.byte_ready;
         @(posedge clk);
         #1 bus.byte_valid = 1'b0;
      end
      check_val("byte_accepted", 64'(acc), 64'd1);
   endtask

   // Words i = 32'h0000_000i at addr i, then the checksum byte
   task automatic send_program(input bit throttle, input bit bad_sum);
      logic [7:0] sum;
      sum = 8'd0;
      for (int w = 0; w < 16; w++) begin
         exp_q.push_back({4'(w), 32'(w)});
         send_byte(8'(w), throttle);
         sum = sum ^ 8'(w);
         for (int k = 0; k < 3; k++) send_byte(8'd0, throttle);
      end
      send_byte(bad_sum ? 8'h5A : sum, throttle);
   endtask

   task automatic check_finish(input string tag, input bit good);
      @(negedge clk);
      check_val({tag, "_done"},  64'(load_done),  64'(good));
      check_val({tag, "_cpurst"}, 64'(cpu_rst),   64'(good));
      check_val({tag, "_error"}, 64'(load_error), 64'(!good));
      check_val({tag, "_state"}, 64'(o_state),    good ? 64'(ST_DONE) : 64'(ST_ERR));
      check_val({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      rst            = 1'b0;
      load_start     = 1'b0;
      bus.byte_in    = 8'd0;
      bus.byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_val("reset_outputs",
                {25'd0, bus.byte_ready, bus.mem_wen, bus.mem_addr, bus.mem_wdata,
                 cpu_rst, load_done, load_error}, 64'd0);
      check_val("reset_state", 64'(o_state), 64'(ST_IDLE));
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_val("idle_ready_low", 64'(bus.byte_ready), 64'd0);

      // 1: full load, no gaps
      pulse_start();
      check_val("start_ready", 64'(bus.byte_ready), 64'd1);
      check_val("start_state", 64'(o_state), 64'(ST_LOAD));
      send_program(1'b0, 1'b0);
      check_finish("s1", 1'b1);
      // bytes offered in DONE are ignored
      @(negedge clk);
      bus.byte_in    = 8'hFF;
      bus.byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.byte_valid = 1'b0;
      check_val("done_ready_low", 64'(bus.byte_ready), 64'd0);
      check_val("done_hold", 64'(load_done), 64'd1);

      // 2: throttled source
      pulse_start();
      check_val("restart_clears_done", 64'(load_done), 64'd0);
      check_val("restart_cpurst_low", 64'(cpu_rst), 64'd0);
      send_program(1'b1, 1'b0);
      check_finish("s2", 1'b1);

      // 3: bad checksum
      pulse_start();
      send_program(1'b0, 1'b1);
      check_finish("s3", 1'b0);
      repeat (3) @(negedge clk);
      check_val("s3_cpurst_stays_low", 64'(cpu_rst), 64'd0);

      // 4: restart after 2 bytes of word 5
      pulse_start();
      check_val("restart_clears_error", 64'(load_error), 64'd0);
      for (int w = 0; w < 5; w++) begin
         exp_q.push_back({4'(w), 32'(w)});
         send_byte(8'(w), 1'b0);
         for (int k = 0; k < 3; k++) send_byte(8'd0, 1'b0);
      end
      send_byte(8'h05, 1'b0);
      send_byte(8'h00, 1'b0);
      check_val("s4_partial_q_empty", 64'(exp_q.size()), 64'd0);
      pulse_start();
      send_program(1'b0, 1'b0);
      check_finish("s4", 1'b1);

      // 6: load_start coincident with an accepted byte
      pulse_start();
      @(negedge clk);
      load_start     = 1'b1;
      bus.byte_in    = 8'hAA;
      bus.byte_valid = 1'b1;
      check_val("s6_collision_ready", 64'(bus.byte_ready), 64'd1);
      @(negedge clk);
      load_start     = 1'b0;
      bus.byte_valid = 1'b0;
      exp_q.push_back({4'd0, 32'h4433_2211});
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      repeat (3) @(negedge clk);
      check_val("s6_q_empty", 64'(exp_q.size()), 64'd0);

      // 5: asynchronous reset mid-word
      send_byte(8'h77, 1'b0);
      send_byte(8'h88, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_val("s5_async_outputs",
                {25'd0, bus.byte_ready, bus.mem_wen, bus.mem_addr, bus.mem_wdata,
                 cpu_rst, load_done, load_error}, 64'd0);
      check_val("s5_async_state", 64'(o_state), 64'(ST_IDLE));
      @(negedge clk);
      rst            = 1'b1;
      bus.byte_in    = 8'h99;
      bus.byte_valid = 1'b1;
      repeat (6) @(negedge clk);
      bus.byte_valid = 1'b0;
      check_val("s5_idle_after_reset", 64'(o_state), 64'(ST_IDLE));
      check_val("s5_ready_low", 64'(bus.byte_ready), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
